// File: rtl/sp1_skid_pkg.sv
// sp1_skid_pkg: shared types for the sp1 two-entry skid buffer.
//   skid_state_e : occupancy state (EMPTY / ONE / FULL); encoding 2'd3 is illegal.
package sp1_skid_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,  // no entries
    StOne   = 2'd1,  // main valid
    StFull  = 2'd2   // main and skid valid
  } skid_state_e;

endpackage

// File: rtl/sp1_ff.sv
// sp1_ff: plain data register with load enable and synchronous active-high reset to zero.
//   clk : clock
//   rst : synchronous reset, clears q
//   en  : load enable
//   d   : next data
//   q   : registered data
module sp1_ff #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sp1_skid.sv
// sp1_skid: two-entry valid/ready pipeline buffer between producer and consumer stages.
// Full throughput; in_ready is derived only from the state register and rst.
//   clk       : clock
//   rst       : synchronous reset, active-high, priority over flush
//   flush     : discard buffered data (data registers keep their contents)
//   in_valid  : producer has data         in_ready  : buffer can accept this cycle
//   in_data   : producer data
//   out_valid : out_data is valid         out_ready : consumer accepts this cycle
//   out_data  : head data (main register)
//   stall_cnt : saturating count of out_valid & ~out_ready cycles
// Optional feature macro: SP1_SKID_STAT_EN adds parameter CW and port stall_cnt.
module sp1_skid
  import sp1_skid_pkg::*;
#(
  parameter int unsigned DW = 32
`ifdef SP1_SKID_STAT_EN
  ,
  parameter int unsigned CW = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef SP1_SKID_STAT_EN
  ,
  output logic [CW-1:0] stall_cnt
`endif
);

  skid_state_e   state_q, state_d;
  logic          in_acc, out_acc;
  logic          main_en, skid_en;
  logic [DW-1:0] main_d, main_q, skid_q;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (in_acc) state_d = StOne;
        StOne: begin
          if (in_acc && !out_acc) begin
            state_d = StFull;
          end else if (!in_acc && out_acc) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (out_acc) state_d = StOne;
        default: state_d = StEmpty;  // illegal encoding recovers to empty
      endcase
    end
  end

  // Output and register-enable decode
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (state_q != StFull) & ~rst;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = in_data;
    case (state_q)
      StEmpty: main_en = in_acc;
      StOne: begin
        main_en = in_acc & out_acc;
        skid_en = in_acc & ~out_acc;
      end
      StFull: begin
        // Drain the overflow entry into the head register.
        main_en = out_acc;
        main_d  = skid_q;
      end
      default: begin
        main_en = 1'b0;
        skid_en = 1'b0;
      end
    endcase
  end

  sp1_ff #(.W(DW)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  sp1_ff #(.W(DW)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  assign out_data = main_q;

`ifdef SP1_SKID_STAT_EN
  logic [CW-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CW{1'b1}})) begin
      stall_q <= stall_q + CW'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sp1_skid.sv
module tb_sp1_skid;

  localparam int unsigned DW = 32;
`ifdef SP1_SKID_STAT_EN
  localparam int unsigned CW = 4;
  logic [CW-1:0] stall_cnt;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp1_skid #(
    .DW (DW)
`ifdef SP1_SKID_STAT_EN
    ,
    .CW (CW)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SP1_SKID_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic          chk_d;
    logic [DW-1:0] e_d;
    string         name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input logic e_ir, input logic e_ov, input logic chk_d,
                     input logic [DW-1:0] e_d, input string name);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e_d = e_d; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                       input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // Hold the given inputs for n clock edges, ending #1 after the last edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic f, input int n);
    drive(1'b0, f, iv, d, ordy);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] sb[$];
  logic          pend_v;
  logic [DW-1:0] pend_d;
  logic          acc_in, acc_out;

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Reset, with in_valid held high.
    for (int i = 0; i < 3; i++) add(1, 0, 1, 32'h55, 0, 0, 0, 1, 32'h0, "reset");
    add(0, 0, 0, 0, 0, 1, 0, 1, 32'h0, "post_reset");
    // Streaming 1..8 with out_ready high.
    for (int k = 1; k <= 8; k++) add(0, 0, 1, DW'(k), 1, 1, 1, 1, DW'(k), "stream");
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, "stream_drain");
    // Back-pressure: A, B accepted, C held off.
    add(0, 0, 1, 32'hA, 0, 1, 1, 1, 32'hA, "bp_push_a");
    add(0, 0, 1, 32'hB, 0, 0, 1, 1, 32'hA, "bp_push_b");
    add(0, 0, 1, 32'hC, 0, 0, 1, 1, 32'hA, "bp_hold_c1");
    add(0, 0, 1, 32'hC, 0, 0, 1, 1, 32'hA, "bp_hold_c2");
    add(0, 0, 1, 32'hC, 1, 1, 1, 1, 32'hB, "bp_release_b");
    add(0, 0, 1, 32'hC, 1, 1, 1, 1, 32'hC, "bp_take_c");
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, "bp_drain");
    // Flush from FULL with a competing input.
    add(0, 0, 1, 32'hA, 0, 1, 1, 1, 32'hA, "fl_push_a");
    add(0, 0, 1, 32'hB, 0, 0, 1, 1, 32'hA, "fl_push_b");
    add(0, 1, 1, 32'hD, 0, 1, 0, 0, 0, "flush_full");
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, "flush_no_d");
    // Flush from ONE with simultaneous in_acc and out_acc.
    add(0, 0, 1, 32'h5, 0, 1, 1, 1, 32'h5, "fl1_push");
    add(0, 1, 1, 32'h6, 1, 1, 0, 0, 0, "flush_one");
    // Reset wins over flush and clears data.
    add(0, 0, 1, 32'h7, 0, 1, 1, 1, 32'h7, "rf_push");
    add(1, 1, 1, 32'h8, 1, 0, 0, 1, 32'h0, "rst_over_flush");
    add(0, 0, 0, 0, 0, 1, 0, 1, 32'h0, "rst_release");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clk);
      #1;
      check({vecs[i].name, ".in_ready"}, DW'(in_ready), DW'(vecs[i].e_ir));
      check({vecs[i].name, ".out_valid"}, DW'(out_valid), DW'(vecs[i].e_ov));
      if (vecs[i].chk_d) check({vecs[i].name, ".out_data"}, out_data, vecs[i].e_d);
    end

`ifdef SP1_SKID_STAT_EN
    // Stall counter: the push edge sees EMPTY, so no count there.
    step(1'b1, 32'h11, 1'b0, 1'b0, 1);
    check("stall_push", DW'(stall_cnt), 0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 5);
    check("stall_5", DW'(stall_cnt), 5);
    step(1'b0, 32'h0, 1'b0, 1'b0, 15);
    check("stall_sat", DW'(stall_cnt), 15);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    check("stall_flush", DW'(stall_cnt), 0);
    check("stall_flush.out_valid", DW'(out_valid), 0);
`endif

    // Random handshakes against a scoreboard queue.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend_v = 1'b0;
    pend_d = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pend_d = $urandom;
      end
      in_valid  = pend_v;
      in_data   = pend_d;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd.out_valid", DW'(out_valid), DW'(sb.size() != 0));
      check("rnd.in_ready", DW'(in_ready), DW'(sb.size() < 2));
      acc_in  = in_valid & in_ready;
      acc_out = out_valid & out_ready;
      if (acc_out && sb.size() != 0) check("rnd.out_data", out_data, sb.pop_front());
      if (acc_in) begin
        sb.push_back(pend_d);
        pend_v = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
